// File: rtl/video_timing.sv
// Raster timing generator: free-running h/v counters advanced by a pixel enable, with
// registered sync, data-enable, coordinates and line/frame strobes. Optional macro: VIDEO_TIMING_LINE_DOUBLE_EN.
module video_timing #(
    parameter int H_ACTIVE        = 640,
    parameter int H_FRONT         = 16,
    parameter int H_SYNC          = 96,
    parameter int H_BACK          = 48,
    parameter int V_ACTIVE        = 480,
    parameter int V_FRONT         = 10,
    parameter int V_SYNC          = 2,
    parameter int V_BACK          = 33,
    parameter int SYNC_ACTIVE_LOW = 1
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       en_i,
    output logic       hsync_o,
    output logic       vsync_o,
    output logic       de_o,
    output logic [9:0] pixel_x_o,
    output logic [9:0] pixel_y_o,
    output logic       line_start_o,
    output logic       frame_start_o
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_size_check
        $error("video_timing: H_TOTAL and V_TOTAL must not exceed 1024");
    end

    // Thresholds are 11 bits so a sync end of exactly 1024 still compares correctly.
    localparam logic [10:0] H_ACT = 11'(H_ACTIVE);
    localparam logic [10:0] H_SS  = 11'(H_ACTIVE + H_FRONT);
    localparam logic [10:0] H_SE  = 11'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [10:0] V_ACT = 11'(V_ACTIVE);
    localparam logic [10:0] V_SS  = 11'(V_ACTIVE + V_FRONT);
    localparam logic [10:0] V_SE  = 11'(V_ACTIVE + V_FRONT + V_SYNC);
    localparam logic [9:0]  H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
    localparam logic        SYNC_OFF = (SYNC_ACTIVE_LOW != 0);

    logic [9:0]  h_cnt, v_cnt;
    logic [10:0] h_ext, v_ext;
    logic        de_d, hs_d, vs_d;
    logic [9:0]  y_d;

    assign h_ext = {1'b0, h_cnt};
    assign v_ext = {1'b0, v_cnt};

    // Decode of the current (pre-increment) position; registered on the enabled edge.
    always_comb begin
        de_d = (h_ext < H_ACT) && (v_ext < V_ACT);
        hs_d = ((h_ext >= H_SS) && (h_ext < H_SE)) ? ~SYNC_OFF : SYNC_OFF;
        vs_d = ((v_ext >= V_SS) && (v_ext < V_SE)) ? ~SYNC_OFF : SYNC_OFF;
`ifdef VIDEO_TIMING_LINE_DOUBLE_EN
        y_d  = {1'b0, v_cnt[9:1]};
`else
        y_d  = v_cnt;
`endif
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            h_cnt         <= '0;
            v_cnt         <= '0;
            hsync_o       <= SYNC_OFF;
            vsync_o       <= SYNC_OFF;
            de_o          <= 1'b0;
            pixel_x_o     <= '0;
            pixel_y_o     <= '0;
            line_start_o  <= 1'b0;
            frame_start_o <= 1'b0;
        end else if (en_i) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
            end else begin
                h_cnt <= h_cnt + 10'd1;
            end
            hsync_o       <= hs_d;
            vsync_o       <= vs_d;
            de_o          <= de_d;
            pixel_x_o     <= h_cnt;
            pixel_y_o     <= y_d;
            line_start_o  <= (h_cnt == '0);
            frame_start_o <= (h_cnt == '0) && (v_cnt == '0);
        end else begin
            // Level outputs hold; strobes only follow an enabled edge.
            line_start_o  <= 1'b0;
            frame_start_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_video_timing.sv
// Bench for video_timing with a reduced raster; expected outputs come from a count of
// enabled edges since reset, mapped to a raster position with plain arithmetic.
module tb_video_timing;

    localparam int HA = 12, HF = 3, HS = 4, HB = 5;
    localparam int VA = 8,  VF = 2, VS = 3, VB = 4;
    localparam int HT = HA + HF + HS + HB;   // 24
    localparam int VT = VA + VF + VS + VB;   // 17
    localparam int FT = HT * VT;             // 408

    logic       clk = 1'b0;
    logic       reset_i = 1'b1;
    logic       en_i = 1'b1;
    logic       hsync_o, vsync_o, de_o, line_start_o, frame_start_o;
    logic [9:0] pixel_x_o, pixel_y_o;

    int checks = 0;
    int errors = 0;

    // Reference state: enabled edges since the last reset, and whether the last edge was enabled.
    int n_edges = 0;
    bit last_en = 1'b0;
    bit started = 1'b0;

    video_timing #(
        .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .SYNC_ACTIVE_LOW(1)
    ) dut (
        .clk_i(clk), .reset_i(reset_i), .en_i(en_i),
        .hsync_o(hsync_o), .vsync_o(vsync_o), .de_o(de_o),
        .pixel_x_o(pixel_x_o), .pixel_y_o(pixel_y_o),
        .line_start_o(line_start_o), .frame_start_o(frame_start_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Raster position currently shown on the outputs, per the reference.
    function automatic void model_pos(output int x, output int y);
        int p;
        p = (n_edges - 1) % FT;
        x = p % HT;
        y = p / HT;
    endfunction

    always @(posedge clk) begin
        if (reset_i) begin
            started = 1'b1;
            n_edges = 0;
        end else if (en_i) begin
            n_edges++;
        end
        last_en = !reset_i && en_i;
    end

    // Per-cycle comparison of every output against the reference.
    always @(negedge clk) begin
        int x, y, ey;
        bit e_de, e_hs, e_vs, e_ls, e_fs;
        if (started) begin
            if (n_edges == 0) begin
                x = 0; y = 0; ey = 0;
                e_de = 0; e_hs = 1; e_vs = 1; e_ls = 0; e_fs = 0;
            end else begin
                model_pos(x, y);
`ifdef VIDEO_TIMING_LINE_DOUBLE_EN
                ey = y / 2;
`else
                ey = y;
`endif
                e_de = (x < HA) && (y < VA);
                e_hs = !((x >= HA + HF) && (x < HA + HF + HS));
                e_vs = !((y >= VA + VF) && (y < VA + VF + VS));
                e_ls = last_en && (x == 0);
                e_fs = last_en && (x == 0) && (y == 0);
            end
            check("pixel_x", int'(pixel_x_o), x);
            check("pixel_y", int'(pixel_y_o), ey);
            check("de", int'(de_o), int'(e_de));
            check("hsync", int'(hsync_o), int'(e_hs));
            check("vsync", int'(vsync_o), int'(e_vs));
            check("line_start", int'(line_start_o), int'(e_ls));
            check("frame_start", int'(frame_start_o), int'(e_fs));
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Count clocks until the selected strobe is seen (1 = frame, 0 = line), bounded by budget.
    task automatic wait_strobe(input bit frame, input int budget, output int clks);
        clks = 0;
        do begin
            @(negedge clk);
            clks++;
        end while (!(frame ? frame_start_o : line_start_o) && clks < budget);
    endtask

    task automatic wait_pos(input int tx, input int ty, input string name);
        int x, y, k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
            model_pos(x, y);
        end while (!(n_edges > 0 && x == tx && y == ty) && k < 3 * FT);
        check({name, "_reached"}, int'(k < 3 * FT), 1);
    endtask

    initial begin
        int c;
        // Reset held three clocks with enable high.
        reset_i = 1'b1; en_i = 1'b1;
        repeat (3) step();
        @(negedge clk);
        check("rst_hsync", int'(hsync_o), 1);
        check("rst_vsync", int'(vsync_o), 1);
        check("rst_de", int'(de_o), 0);
        check("rst_fs", int'(frame_start_o), 0);
        reset_i = 1'b0;
        step();
        @(negedge clk);
        check("first_fs", int'(frame_start_o), 1);
        check("first_ls", int'(line_start_o), 1);
        check("first_de", int'(de_o), 1);
        check("first_x", int'(pixel_x_o), 0);
        repeat (12) @(negedge clk);
        check("x12_de", int'(de_o), 0);
        check("x12_x", int'(pixel_x_o), 12);
        repeat (3) @(negedge clk);
        check("x15_hsync", int'(hsync_o), 0);
        repeat (4) @(negedge clk);
        check("x19_hsync", int'(hsync_o), 1);

        // Frame strobe spacing with continuous enable: 24*17 = 408 clocks.
        wait_strobe(1'b1, 1000, c);
        check("fs_sync", int'(c < 1000), 1);
        wait_strobe(1'b1, 1000, c);
        check("fs_spacing", c, 408);

        // Line doubling around the last active line and first blanking line.
        wait_pos(0, 7, "line7");
`ifdef VIDEO_TIMING_LINE_DOUBLE_EN
        check("line7_y", int'(pixel_y_o), 3);
`else
        check("line7_y", int'(pixel_y_o), 7);
`endif
        wait_pos(0, 8, "line8");
`ifdef VIDEO_TIMING_LINE_DOUBLE_EN
        check("line8_y", int'(pixel_y_o), 4);
`else
        check("line8_y", int'(pixel_y_o), 8);
`endif
        wait_pos(0, 10, "line10");
        check("line10_vsync", int'(vsync_o), 0);

        // Enable every other clock: line period doubles to 48 clocks.
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    en_i = ~en_i;
                    step();
                end
                en_i = 1'b1;
            end
            begin
                wait_strobe(1'b0, 200, c);
                check("ls_sync", int'(c < 200), 1);
                wait_strobe(1'b0, 200, c);
                check("ls_spacing_half_rate", c, 48);
            end
        join

        // Mid-frame reset at (7,5).
        wait_pos(7, 5, "mid");
        reset_i = 1'b1;
        step();
        reset_i = 1'b0; en_i = 1'b0;
        @(negedge clk);
        check("mid_rst_x", int'(pixel_x_o), 0);
        check("mid_rst_hsync", int'(hsync_o), 1);
        step();
        en_i = 1'b1;
        step();
        @(negedge clk);
        check("mid_restart_fs", int'(frame_start_o), 1);
        check("mid_restart_y", int'(pixel_y_o), 0);

        // Randomized enable with occasional resets.
        for (int i = 0; i < 2500; i++) begin
            en_i    = ($urandom_range(0, 3) != 0);
            reset_i = ($urandom_range(0, 399) == 0);
            step();
        end
        reset_i = 1'b0; en_i = 1'b1;
        repeat (2 * FT) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/video_timing.md
# video_timing

Raster timing generator that drives the pixel coordinates consumed by the overlay/object stages (title, sprites, score) and the sync outputs to the display. It holds free-running horizontal and vertical counters advanced by a pixel-rate enable and emits aligned `hsync`/`vsync`, data-enable, pixel coordinates and line/frame start strobes. In the video pipeline it is the first stage: every object block's `pixel_x_i`/`pixel_y_i` comes from here.

## Interface

- `H_ACTIVE`, default 640: visible pixels per line.
- `H_FRONT`, default 16: horizontal front porch, in pixels.
- `H_SYNC`, default 96: hsync pulse width, in pixels.
- `H_BACK`, default 48: horizontal back porch; `H_TOTAL = sum` = 800.
- `V_ACTIVE`, default 480: visible physical lines.
- `V_FRONT`, default 10: vertical front porch, in lines.
- `V_SYNC`, default 2: vsync width, in lines.
- `V_BACK`, default 33: vertical back porch; `V_TOTAL` = 525.
- `SYNC_ACTIVE_LOW`, default 1: 1 means sync outputs are low while asserted.

- `clk_i`, in, 1: system clock.
- `reset_i`, in, 1: synchronous, active-high reset.
- `en_i`, in, 1: pixel-rate enable; counters advance only on cycles where it is high.
- `hsync_o`, out, 1: horizontal sync, polarity per `SYNC_ACTIVE_LOW`.
- `vsync_o`, out, 1: vertical sync, polarity per `SYNC_ACTIVE_LOW`.
- `de_o`, out, 1: high while the position is inside the active area.
- `pixel_x_o`, out, 10: horizontal position, 0..`H_TOTAL`-1.
- `pixel_y_o`, out, 10: vertical logical position (see Configuration).
- `line_start_o`, out, 1: one-clock pulse marking the start of a line (x = 0).
- `frame_start_o`, out, 1: one-clock pulse marking the start of a frame (x = 0, y = 0).

## Operation

- **Internal counters.** `h_cnt` and `v_cnt` are each 10 bits.
- **Counter update.** Applies on every `clk_i` edge with `en_i`=1.
  - `h_cnt` increments.
  - At `H_TOTAL`-1, `h_cnt` wraps to 0 and `v_cnt` increments.
  - At (`H_TOTAL`-1, `V_TOTAL`-1), both counters wrap to 0.
- **Output registers.** On the same enabled edge, the output registers load the decode of the pre-increment (`h_cnt`, `v_cnt`):
  - `de` = `h < H_ACTIVE && v < V_ACTIVE`.
  - hsync asserted for `H_ACTIVE+H_FRONT <= h < H_ACTIVE+H_FRONT+H_SYNC`.
  - vsync asserted for `V_ACTIVE+V_FRONT <= v < V_ACTIVE+V_FRONT+V_SYNC`.
  - `pixel_x_o = h`; `pixel_y_o` per Configuration.
- **Output alignment.** All outputs are registered and always describe the same position. Coordinates are not clamped during blanking; downstream stages gate on `de_o` or on their own bounds.
- **Start strobes.** Both are single-clock pulses, asserted in the clock after the enabled edge that loaded the position.
  - `line_start_o` fires when h = 0 is loaded.
  - `frame_start_o` fires when (0,0) is loaded; `line_start_o` is also high in that cycle.
  - Both are 0 in every other cycle, including non-enabled cycles.
- **`en_i` = 0.** Counters and level outputs hold their values; strobes are 0.
- **Reset.** Reset overrides `en_i` and takes effect on the next edge, including mid-frame. Reset values:
  - counters = 0;
  - `hsync_o` and `vsync_o` deasserted (high when `SYNC_ACTIVE_LOW`=1);
  - `de_o` = 0, `pixel_x_o` = 0, `pixel_y_o` = 0;
  - `line_start_o` = 0, `frame_start_o` = 0.
- **First frame after reset.** The first enabled edge after reset release loads (0,0), so `frame_start_o` and `de_o` rise one clock later. No partial frame is produced.
- **Width rule.** `H_TOTAL` and `V_TOTAL` must be at most 1024. Elaboration fails via assertion otherwise.

## Timing

- **Latency.** Outputs lag the internal counter by exactly one enabled edge. Hsync/vsync/de change only on enabled edges and never glitch.
- **Line and frame period.** One line is `H_TOTAL` enabled cycles; one frame is `H_TOTAL*V_TOTAL` enabled cycles. With `en_i` every other clock, the line period is 1600 clk.
- **Defaults (in enabled cycles).**
  - hsync asserted for x = 656..751, 96 enabled cycles.
  - vsync asserted for lines 490..491.
  - `de_o` high for x = 0..639 on lines 0..479.
- **Strobe spacing.** `frame_start_o` pulses are exactly 420000 enabled cycles apart.

## Configuration

- **`VIDEO_TIMING_LINE_DOUBLE_EN` defined:** `pixel_y_o = v_cnt >> 1`.
  - 480 physical lines map to logical rows 0..239, so each logical row is output on two consecutive lines.
  - This matches the 640x240 object stages.
- **Macro undefined:** `pixel_y_o = v_cnt`, range 0..`V_TOTAL`-1.
- **Unaffected by the macro:** all other outputs and timing.

## Test plan

- **Reset values.** Hold `reset_i` 3 clocks with `en_i`=1, then release.
  - During reset: `hsync_o`=`vsync_o`=1, `de_o`=0, coordinates 0, strobes 0.
  - First enabled edge after release: the next clock shows `frame_start_o`=1, `line_start_o`=1, `de_o`=1, (0,0).
- **Horizontal timing.** With `en_i`=1, check across one line:
  - `de_o` falls when x goes 639→640;
  - `hsync_o` is low for x = 656..751 and high at 752;
  - x wraps 799→0 and the vertical count increments;
  - `line_start_o` pulses once.
- **Frame wrap.** Run to position (799,524).
  - Next position is (0,0) with `frame_start_o`=1.
  - `vsync_o` is low only on lines 490..491.
  - Strobe spacing is 420000 clocks.
- **Enable gating.** Drive `en_i` high every other clock.
  - Outputs hold during `en_i`=0 cycles.
  - Line period is 1600 clocks.
  - Each strobe is high for exactly one clock.
- **Line doubling.** With the macro defined, lines 478/479 give `pixel_y_o` = 239, and line 480 gives 240. With the macro undefined, line 479 gives 479.
- **Mid-frame reset.** Assert `reset_i` for 1 clock at position (400,300).
  - Outputs return to reset values on the next edge.
  - The first enabled edge after release restarts at (0,0) with `frame_start_o`.
